// File: rtl/image_morph_nxn_pkg.sv
// Shared constants, sync bundle type and neutral-value helper for the
// binary morphology stage.
package isp_morph_pkg;
   localparam logic MODE_ERODE  = 1'b0;
   localparam logic MODE_DILATE = 1'b1;
   localparam int   PIPE_LAT    = 3;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
   } sync_t;

   // Value that leaves an AND (erode) or OR (dilate) reduction unchanged.
   function automatic logic neutral(input logic mode);
      return ~mode;
   endfunction
endpackage

// File: rtl/image_morph_nxn_line_buffer.sv
// Cascaded 1-bit line stores: row k returns the bit written k+1 lines earlier
// at the same column (read-before-write).
module morph_line_buffer #(
   parameter  int DEPTH = 1024,
   parameter  int ROWS  = 2,
   localparam int AW    = $clog2(DEPTH)
)(
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   addr,
   input  logic            din,
   output logic [ROWS-1:0] dout
);
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DEPTH-1:0] mem_q;

      assign dout[r] = mem_q[addr];

      if (r == 0) begin : g_head
         always_ff @(posedge clk) begin
            if (we) mem_q[addr] <= din;
         end
      end else begin : g_tail
         always_ff @(posedge clk) begin
            if (we) mem_q[addr] <= g_row[r-1].mem_q[addr];
         end
      end
   end
endmodule

// File: rtl/image_morph_nxn.sv
// Binarise against a per-frame threshold, then KSIZE x KSIZE erosion/dilation.
// Output is referenced to the bottom-right window tap; latency is 3 cycles.
module image_morph_nxn
   import isp_morph_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int KSIZE  = 3,
   parameter int MAX_W  = 1024
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hsync_i,
   input  logic              vsync_i,
   input  logic              de_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              mode_i,
   input  logic [DATA_W-1:0] thresh_i,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              de_o,
   output logic [DATA_W-1:0] data_o,
   output logic              ovf_o
);
   localparam int            CW      = $clog2(MAX_W) + 1;
   localparam int            AW      = $clog2(MAX_W);
   localparam logic [CW-1:0] MAX_W_C = CW'(MAX_W);
   localparam logic [CW-1:0] CNT_SAT = '1;

   if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
      $error("image_morph_nxn: KSIZE must be 3 or 5");
   end

   sync_t               sync_q   [PIPE_LAT];
   sync_t               sync_d   [PIPE_LAT];
   logic                mode_q, mode_d;
   logic [DATA_W-1:0]   thresh_q, thresh_d;
   logic [CW-1:0]       col_q, col_d, row_q, row_d;
   logic                ovf_q, ovf_d;
   logic [KSIZE-2:0]    hist_q   [KSIZE];
   logic [KSIZE-2:0]    hist_d   [KSIZE];
   logic [KSIZE-1:0]    win_q    [KSIZE];
   logic [KSIZE-1:0]    win_d    [KSIZE];
   logic [KSIZE-1:0]    red_q, red_d;
   logic [1:0]          mode_p_q, mode_p_d;
   logic                res_q, res_d;

   logic [KSIZE-2:0]    lb_dout;
   logic [KSIZE-1:0]    col_vec;
   logic                vs_rise, de_fall, in_frame, bin, nz;

   assign vs_rise  = vsync_i & ~sync_q[0].vsync;
   assign de_fall  = sync_q[0].de & ~de_i;
   assign in_frame = col_q < MAX_W_C;
   assign bin      = data_i >= thresh_q;
   assign nz       = neutral(mode_q);

   morph_line_buffer #(
      .DEPTH (MAX_W),
      .ROWS  (KSIZE-1)
   ) u_lbuf (
      .clk  (clk),
      .we   (de_i & in_frame),
      .addr (col_q[AW-1:0]),
      .din  (bin),
      .dout (lb_dout)
   );

   // Vertical taps for the current column; rows above the frame top and
   // overflow columns fall back to the neutral value.
   always_comb begin
      col_vec[0] = bin;
      for (int r = 1; r < KSIZE; r++)
         col_vec[r] = (row_q < CW'(r) || !in_frame) ? nz : lb_dout[r-1];
   end

   always_comb begin
      mode_d   = mode_q;
      thresh_d = thresh_q;
      col_d    = col_q;
      row_d    = row_q;
      ovf_d    = ovf_q;

      if (vs_rise) begin
         mode_d   = mode_i;
         thresh_d = thresh_i;
      end

      if (de_fall)                         col_d = '0;
      else if (de_i && col_q != CNT_SAT)   col_d = col_q + 1'b1;

      if (vs_rise)                         row_d = '0;
      else if (de_fall && row_q != CNT_SAT) row_d = row_q + 1'b1;

      if (vs_rise)                         ovf_d = 1'b0;
      else if (de_i && !in_frame)          ovf_d = 1'b1;

      // S1 window assembly, S2 per-row reduction
      for (int r = 0; r < KSIZE; r++) begin
         hist_d[r]    = de_i ? {hist_q[r][KSIZE-3:0], col_vec[r]} : hist_q[r];
         win_d[r]     = '0;
         win_d[r][0]  = col_vec[r];
         for (int c = 1; c < KSIZE; c++)
            win_d[r][c] = (col_q < CW'(c)) ? nz : hist_q[r][c-1];
         red_d[r] = (mode_p_q[0] == MODE_DILATE) ? |win_q[r] : &win_q[r];
      end

      mode_p_d = {mode_p_q[0], mode_q};
      res_d    = ((mode_p_q[1] == MODE_DILATE) ? |red_q : &red_q) & sync_q[1].de;

      sync_d[0] = {hsync_i, vsync_i, de_i};
      for (int i = 1; i < PIPE_LAT; i++)
         sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= MODE_ERODE;
         thresh_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         ovf_q    <= 1'b0;
         red_q    <= '0;
         mode_p_q <= '0;
         res_q    <= 1'b0;
         for (int r = 0; r < KSIZE; r++) begin
            hist_q[r] <= '0;
            win_q[r]  <= '0;
         end
         for (int i = 0; i < PIPE_LAT; i++)
            sync_q[i] <= '0;
      end else begin
         mode_q   <= mode_d;
         thresh_q <= thresh_d;
         col_q    <= col_d;
         row_q    <= row_d;
         ovf_q    <= ovf_d;
         red_q    <= red_d;
         mode_p_q <= mode_p_d;
         res_q    <= res_d;
         for (int r = 0; r < KSIZE; r++) begin
            hist_q[r] <= hist_d[r];
            win_q[r]  <= win_d[r];
         end
         for (int i = 0; i < PIPE_LAT; i++)
            sync_q[i] <= sync_d[i];
      end
   end

   assign hsync_o = sync_q[PIPE_LAT-1].hsync;
   assign vsync_o = sync_q[PIPE_LAT-1].vsync;
   assign de_o    = sync_q[PIPE_LAT-1].de;
   assign data_o  = {DATA_W{res_q}};
   assign ovf_o   = ovf_q;
endmodule
